r2sdf_butterfly: RTL



---
 rtl/r2sdf_butterfly_pkg.sv | 26 ++
 rtl/r2sdf_ctrl.sv | 55 +++++
 rtl/r2sdf_butterfly.sv | 79 +++++++
 3 files changed

// File: rtl/r2sdf_butterfly_pkg.sv
// Shared definitions for the FFT butterfly stages: sample width, saturation
// limits, control state encoding and the 20-to-19-bit saturating helper.
package r2sdf_butterfly_pkg;

    localparam int DW      = 19;
    localparam int SAT_MAX = 262143;
    localparam int SAT_MIN = -262144;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Clamp a 20-bit signed intermediate back into the 19-bit sample range.
    function automatic logic [DW-1:0] sat19(input logic signed [DW:0] v);
        if (int'(v) > SAT_MAX) begin
            return DW'(SAT_MAX);
        end else if (int'(v) < SAT_MIN) begin
            return DW'(SAT_MIN);
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/r2sdf_ctrl.sv
// R2SDF stage control: phase counter, IDLE/FILL/RUN state machine and the
// out_start / out_valid stream markers.
module r2sdf_ctrl
    import r2sdf_butterfly_pkg::*;
#(
    parameter int DELAY = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_start,
    output logic [CW-1:0] phase,
    output logic          active,
    output logic          out_valid,
    output logic          out_start
);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mark;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_start <= mark;
            out_valid <= out_valid | mark;
        end
    end

    // The in_start cycle out of IDLE is already processed as phase 0, so the
    // counter advances in that cycle as well.
    always_comb begin
        phase     = in_start ? '0 : cnt;
        active    = (state != ST_IDLE) || in_start;
        mark      = (state != ST_IDLE) && (phase == CW'(DELAY));
        cnt_nxt   = cnt;
        state_nxt = state;
        if (active) begin
            cnt_nxt = phase + 1'b1;
        end
        case (state)
            ST_IDLE: if (in_start) state_nxt = ST_FILL;
            ST_FILL: if (phase == CW'(DELAY)) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/r2sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage; drives and reads an
// external feedback delay line of length DELAY.
module r2sdf_butterfly
    import r2sdf_butterfly_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_start,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_i,
    input  logic [DW-1:0] sr_r,
    input  logic [DW-1:0] sr_i,
    output logic [DW-1:0] fb_r,
    output logic [DW-1:0] fb_i,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_i,
    output logic          out_valid,
    output logic          out_start
);

    localparam int CW = (DELAY < 1) ? 1 : $clog2(2 * DELAY);

    logic [CW-1:0]        phase;
    logic                 active;
    logic                 second_half;
    logic signed [DW:0]   sum_r, sum_i, dif_r, dif_i;
    logic [DW-1:0]        out_r_nxt, out_i_nxt;

    r2sdf_ctrl #(
        .DELAY (DELAY),
        .CW    (CW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .phase     (phase),
        .active    (active),
        .out_valid (out_valid),
        .out_start (out_start)
    );

    // Sums and differences are formed with one guard bit, then clamped.
    always_comb begin
        second_half = (phase >= CW'(DELAY));
        sum_r = $signed({sr_r[DW-1], sr_r}) + $signed({in_r[DW-1], in_r});
        sum_i = $signed({sr_i[DW-1], sr_i}) + $signed({in_i[DW-1], in_i});
        dif_r = $signed({sr_r[DW-1], sr_r}) - $signed({in_r[DW-1], in_r});
        dif_i = $signed({sr_i[DW-1], sr_i}) - $signed({in_i[DW-1], in_i});

        fb_r      = in_r;
        fb_i      = in_i;
        out_r_nxt = '0;
        out_i_nxt = '0;
        if (active) begin
            if (second_half) begin
                fb_r      = sat19(dif_r);
                fb_i      = sat19(dif_i);
                out_r_nxt = sat19(sum_r);
                out_i_nxt = sat19(sum_i);
            end else begin
                out_r_nxt = sr_r;
                out_i_nxt = sr_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r <= '0;
            out_i <= '0;
        end else begin
            out_r <= out_r_nxt;
            out_i <= out_i_nxt;
        end
    end

endmodule
